// File: rtl/seq_cmp_eq.sv
// Multi-cycle MSB-first comparator: CHUNK bits per clock, exits on the first differing chunk.
// Optional build macro SIGNED_CMP_EN treats operands as two's complement.
module seq_cmp_eq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] b1,
  input  logic [WIDTH-1:0] b2,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_CMP  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] sh1_q, sh1_d;
  logic [WIDTH-1:0] sh2_q, sh2_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;

  logic [CHUNK-1:0] c1, c2;
  logic             c_ne, c_gt;

  // Current chunk is always the top CHUNK bits; the registers shift left as chunks match.
  always_comb begin
    c1 = sh1_q[WIDTH-1 -: CHUNK];
    c2 = sh2_q[WIDTH-1 -: CHUNK];
`ifdef SIGNED_CMP_EN
    // Flipping the sign bit of the leading chunk turns a signed order into an unsigned one.
    if (cnt_q == '0) begin
      c1[CHUNK-1] = ~sh1_q[WIDTH-1];
      c2[CHUNK-1] = ~sh2_q[WIDTH-1];
    end
`endif
    c_ne = (c1 != c2);
    c_gt = (c1 > c2);
  end

  always_comb begin
    state_d = state_q;
    sh1_d   = sh1_q;
    sh2_d   = sh2_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    eq_d    = eq_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sh1_d   = b1;
          sh2_d   = b2;
          cnt_d   = '0;
          busy_d  = 1'b1;
          eq_d    = 1'b0;
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          state_d = S_CMP;
        end
      end
      S_CMP: begin
        if (c_ne) begin
          gt_d    = c_gt;
          lt_d    = ~c_gt;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (cnt_q == LAST) begin
          eq_d    = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          sh1_d = sh1_q << CHUNK;
          sh2_d = sh2_q << CHUNK;
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sh1_q   <= '0;
      sh2_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sh1_q   <= sh1_d;
      sh2_q   <= sh2_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign eq   = eq_q;
  assign gt   = gt_q;
  assign lt   = lt_q;

endmodule
